// File: rtl/onehot_gen.sv
// Binary position -> one-hot decoder on valid/ready channels; 1-cycle latency, registered outputs.
// OUT + one SKID slot give full throughput; in_ready is registered and drops only once SKID fills.
module onehot_gen #(
  parameter int VECTOR_W   = 4,
  parameter int POSITION_W = $clog2(VECTOR_W),
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [POSITION_W-1:0] in_position,
  input  logic                  in_zero,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [VECTOR_W-1:0]   out_vector,
  output logic                  out_err,
  output logic [CNT_W-1:0]      err_cnt,
  input  logic                  err_clr
);

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_FULL} state_t;

  state_t              r_state;
  logic [VECTOR_W-1:0] r_out_vec;
  logic [VECTOR_W-1:0] r_skid_vec;
  logic                r_out_err;
  logic                r_skid_err;
  logic                r_out_valid;
  logic                r_in_ready;
  logic [CNT_W-1:0]    r_err_cnt;

  logic [VECTOR_W-1:0] w_dec_vec;
  logic                w_dec_err;
  logic                w_in_xfer;
  logic                w_out_xfer;

  assign w_in_xfer  = in_valid && r_in_ready;
  assign w_out_xfer = r_out_valid && out_ready;

  // Positions past VECTOR_W-1 only exist when VECTOR_W is not a power of two.
  always_comb begin
    w_dec_vec = '0;
    w_dec_err = 1'b0;
    if (!in_zero) begin
      if (int'(in_position) < VECTOR_W) begin
        w_dec_vec = VECTOR_W'(1) << in_position;
      end else begin
        w_dec_err = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_EMPTY;
      r_out_vec   <= '0;
      r_out_err   <= 1'b0;
      r_skid_vec  <= '0;
      r_skid_err  <= 1'b0;
      r_out_valid <= 1'b0;
      r_in_ready  <= 1'b0;
    end else begin
      r_in_ready <= 1'b1;
      case (r_state)
        S_EMPTY: begin
          if (w_in_xfer) begin
            r_out_vec   <= w_dec_vec;
            r_out_err   <= w_dec_err;
            r_out_valid <= 1'b1;
            r_state     <= S_ONE;
          end
        end
        S_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            r_out_vec <= w_dec_vec;
            r_out_err <= w_dec_err;
          end else if (w_in_xfer) begin
            r_skid_vec <= w_dec_vec;
            r_skid_err <= w_dec_err;
            r_in_ready <= 1'b0;
            r_state    <= S_FULL;
          end else if (w_out_xfer) begin
            r_out_valid <= 1'b0;
            r_state     <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (w_out_xfer) begin
            r_out_vec <= r_skid_vec;
            r_out_err <= r_skid_err;
            r_state   <= S_ONE;
          end else begin
            r_in_ready <= 1'b0;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_state     <= S_EMPTY;
        end
      endcase
    end
  end

  // Counted at acceptance; clear has priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err_cnt <= '0;
    end else if (err_clr) begin
      r_err_cnt <= '0;
    end else if (w_in_xfer && w_dec_err && (r_err_cnt != '1)) begin
      r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign in_ready   = r_in_ready;
  assign out_valid  = r_out_valid;
  assign out_vector = r_out_vec;
  assign out_err    = r_out_err;
  assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_onehot_gen.sv
// Scoreboard bench for onehot_gen: a 4-bit instance and a 5-bit instance with a 2-bit error counter.
module tb_onehot_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [7:0] vec;
    logic       err;
    int         cyc;
    bit         lat;
  } exp_t;

  exp_t q4[$];
  exp_t q5[$];

  logic       in_valid4 = 0, in_zero4 = 0, out_ready4 = 1, err_clr4 = 0;
  logic [1:0] in_pos4 = 0;
  logic       in_ready4, out_valid4, out_err4;
  logic [3:0] out_vector4;
  logic [7:0] err_cnt4;

  logic       in_valid5 = 0, in_zero5 = 0, out_ready5 = 1, err_clr5 = 0;
  logic [2:0] in_pos5 = 0;
  logic       in_ready5, out_valid5, out_err5;
  logic [4:0] out_vector5;
  logic [1:0] err_cnt5;

  onehot_gen #(.VECTOR_W(4), .POSITION_W(2), .CNT_W(8)) d4 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid4), .in_ready(in_ready4),
    .in_position(in_pos4), .in_zero(in_zero4), .out_valid(out_valid4),
    .out_ready(out_ready4), .out_vector(out_vector4), .out_err(out_err4),
    .err_cnt(err_cnt4), .err_clr(err_clr4));

  onehot_gen #(.VECTOR_W(5), .POSITION_W(3), .CNT_W(2)) d5 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid5), .in_ready(in_ready5),
    .in_position(in_pos5), .in_zero(in_zero5), .out_valid(out_valid5),
    .out_ready(out_ready5), .out_vector(out_vector5), .out_err(out_err5),
    .err_cnt(err_cnt5), .err_clr(err_clr5));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Inputs change 1 time unit after posedge; acceptance is decided by in_ready at negedge.
  task automatic send4(input int p, input bit z, input logic [7:0] ev, input bit ee,
                       input bit lat, output int waits);
    exp_t e;
    waits = 0;
    in_valid4 = 1; in_pos4 = 2'(p); in_zero4 = z;
    forever begin
      @(negedge clk);
      if (in_ready4) break;
      waits++;
      if (waits > 50) break;
      @(posedge clk); #1;
    end
    if (waits > 50) begin
      chk("d4_accept_timeout", 0, 1);
    end else begin
      e.vec = ev; e.err = ee; e.cyc = cyc; e.lat = lat;
      q4.push_back(e);
    end
    @(posedge clk); #1;
    in_valid4 = 0;
  endtask

  task automatic send5(input int p, input logic [7:0] ev, input bit ee, input bit lat);
    exp_t e;
    int waits;
    waits = 0;
    in_valid5 = 1; in_pos5 = 3'(p); in_zero5 = 0;
    forever begin
      @(negedge clk);
      if (in_ready5) break;
      waits++;
      if (waits > 50) break;
      @(posedge clk); #1;
    end
    if (waits > 50) begin
      chk("d5_accept_timeout", 0, 1);
    end else begin
      e.vec = ev; e.err = ee; e.cyc = cyc; e.lat = lat;
      q5.push_back(e);
    end
    @(posedge clk); #1;
    in_valid5 = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon4
    exp_t e;
    if (rst_n && out_valid4 && out_ready4) begin
      if (q4.size() == 0) begin
        chk("d4_unexpected_beat", {28'd0, out_vector4}, 32'hFFFF_FFFF);
      end else begin
        e = q4.pop_front();
        chk("d4_vector", {28'd0, out_vector4}, {24'd0, e.vec});
        chk("d4_err", {31'd0, out_err4}, {31'd0, e.err});
        if (e.lat) chk("d4_latency", cyc - e.cyc, 1);
      end
    end
  end

  always @(negedge clk) begin : mon5
    exp_t e;
    if (rst_n && out_valid5 && out_ready5) begin
      if (q5.size() == 0) begin
        chk("d5_unexpected_beat", {27'd0, out_vector5}, 32'hFFFF_FFFF);
      end else begin
        e = q5.pop_front();
        chk("d5_vector", {27'd0, out_vector5}, {24'd0, e.vec});
        chk("d5_err", {31'd0, out_err5}, {31'd0, e.err});
        if (e.lat) chk("d5_latency", cyc - e.cyc, 1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_bad=%0d", n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready4, 0);
    chk("rst_out_valid", out_valid4, 0);
    chk("rst_out_vector", out_vector4, 0);
    chk("rst_out_err", out_err4, 0);
    chk("rst_err_cnt", err_cnt4, 0);
    @(posedge clk); #1;
    rst_n = 1;
    @(negedge clk);
    chk("in_ready_before_edge", in_ready4, 0);
    @(negedge clk);
    chk("in_ready_after_edge", in_ready4, 1);
    @(posedge clk); #1;

    // Sweep 0..3 back-to-back, then a zero request with position 2
    send4(0, 0, 8'h01, 0, 1, w);
    send4(1, 0, 8'h02, 0, 1, w);
    send4(2, 0, 8'h04, 0, 1, w);
    send4(3, 0, 8'h08, 0, 1, w);
    send4(2, 1, 8'h00, 0, 1, w);
    idle(3);
    chk("d4_err_cnt_after_zero", err_cnt4, 0);

    // Out of range on the 5-wide instance
    send5(5, 8'h00, 1, 1);
    send5(6, 8'h00, 1, 1);
    send5(7, 8'h00, 1, 1);
    send5(4, 8'h10, 0, 1);
    idle(3);
    chk("d5_err_cnt_3", err_cnt5, 3);

    // Clear, then saturate the 2-bit counter
    err_clr5 = 1; idle(1); err_clr5 = 0;
    @(negedge clk);
    chk("d5_err_cnt_cleared", err_cnt5, 0);
    @(posedge clk); #1;
    send5(5, 8'h00, 1, 1);
    idle(1);
    @(negedge clk);
    chk("d5_err_cnt_1", err_cnt5, 1);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) send5(7, 8'h00, 1, 1);
    idle(2);
    chk("d5_err_cnt_sat", err_cnt5, 3);
    err_clr5 = 1;
    send5(6, 8'h00, 1, 1);
    err_clr5 = 0;
    @(negedge clk);
    chk("d5_clr_beats_inc", err_cnt5, 0);
    idle(3);

    // Backpressure: two beats fit, the third waits
    out_ready4 = 0;
    send4(1, 0, 8'h02, 0, 0, w);
    send4(2, 0, 8'h04, 0, 0, w);
    chk("bp_second_no_wait", w, 0);
    in_valid4 = 1; in_pos4 = 2'd3; in_zero4 = 0;
    @(negedge clk);
    chk("bp_in_ready_low", in_ready4, 0);
    idle(3);
    @(negedge clk);
    chk("bp_in_ready_still_low", in_ready4, 0);
    chk("bp_out_valid_held", out_valid4, 1);
    chk("bp_out_vector_stable", out_vector4, 4'b0010);
    @(posedge clk); #1;
    out_ready4 = 1;
    @(negedge clk);
    chk("bp_in_ready_before_drain", in_ready4, 0);
    send4(3, 0, 8'h08, 0, 0, w);
    chk("bp_in_ready_after_drain", w, 0);
    idle(4);
    chk("bp_queue_drained", q4.size(), 0);

    // Asynchronous reset while FULL
    out_ready4 = 0;
    send4(0, 0, 8'h01, 0, 0, w);
    send4(1, 0, 8'h02, 0, 0, w);
    #2;
    rst_n = 0;
    #1;
    chk("arst_out_valid", out_valid4, 0);
    chk("arst_in_ready", in_ready4, 0);
    q4.delete();
    @(posedge clk); #1;
    rst_n = 1;
    out_ready4 = 1;
    idle(3);
    @(negedge clk);
    chk("arst_no_stale_beat", out_valid4, 0);
    @(posedge clk); #1;
    send4(2, 0, 8'h04, 0, 1, w);
    idle(3);
    chk("final_q4_empty", q4.size(), 0);
    chk("final_q5_empty", q5.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/onehot_gen.md
# onehot_gen

Streaming binary-to-one-hot decoder: accepts a bit position on a valid/ready input channel and presents the matching one-hot vector on a registered valid/ready output channel. It is the inverse of the one-hot-to-position encoder in the same library and uses the same conventions: bit `i` of the vector corresponds to position `i`, and all-zero is a legal vector. A one-entry skid buffer gives full throughput with a registered `in_ready`. A saturating counter records out-of-range requests.

## Interface
- `VECTOR_W`, 4: width of the generated vector; must be ≥ 2.
- `POSITION_W`, `$clog2(VECTOR_W)`: width of the position input.
- `CNT_W`, 8: width of the error counter.

- `clk` in 1: single clock; every register is on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `in_valid` in 1: the input request is valid.
- `in_ready` out 1: the block can accept an input this cycle. Driven directly from a register.
- `in_position` in POSITION_W: index of the bit to set.
- `in_zero` in 1: when 1, request an all-zero vector and ignore `in_position`.
- `out_valid` out 1: the output beat is valid.
- `out_ready` in 1: the consumer accepts the output beat.
- `out_vector` out VECTOR_W: the one-hot or all-zero result.
- `out_err` out 1: the beat came from an out-of-range position.
- `err_cnt` out CNT_W: saturating count of accepted out-of-range requests.
- `err_clr` in 1: synchronous clear of `err_cnt`.

## Operation
- An input transfer happens when `in_valid && in_ready`. An output transfer happens when `out_valid && out_ready`.
- Decode rules:
  - `in_zero`=1: vector = 0, err = 0.
  - Otherwise, if `in_position` < VECTOR_W: vector = 1 << `in_position`, err = 0.
  - Otherwise (possible only when VECTOR_W is not a power of two): vector = 0, err = 1.
- Decoding is done on the input side. The output and skid registers hold the {vector, err} pair already decoded.
- There are two storage slots: OUT (drives the outputs) and SKID. The states are:
  - EMPTY: OUT is empty.
  - ONE: OUT is full, SKID is empty.
  - FULL: both are full.
- State transitions:
  - EMPTY + input transfer → ONE. The input is loaded into OUT.
  - ONE + input transfer + output transfer → ONE. OUT is reloaded with the input.
  - ONE + input transfer, no output transfer → FULL. The input goes to SKID.
  - ONE + output transfer, no input transfer → EMPTY.
  - FULL + output transfer → ONE. SKID moves into OUT. No input is accepted in FULL.
- Ordering is strictly in-order. A beat held in SKID always reaches OUT before any later input.
- `in_ready` is registered. It is 1 in EMPTY and ONE and 0 in FULL, with the next-state value computed every cycle.
- Error counter:
  - Increments by 1 on each input transfer whose decoded err = 1. It saturates at 2^CNT_W−1.
  - The increment happens at acceptance, not at output.
  - `err_clr` forces 0. If `err_clr` and an increment occur in the same cycle, the clear wins and the increment is dropped.
- Reset mid-operation: the contents of OUT and SKID are discarded. No partial beat is emitted.

## Timing
- Reset values:
  - `out_valid`=0, `out_vector`=0, `out_err`=0, `err_cnt`=0.
  - `in_ready`=0 while `rst_n` is low. It rises to 1 on the first `clk` edge after `rst_n` is released.
- Latency: an input accepted at edge N appears with `out_valid`=1 after edge N, when OUT was empty or drained in the same cycle.
- Throughput: one beat per cycle while `out_ready`=1.
- Backpressure: at most one extra beat is accepted after `out_ready` falls. `in_ready` drops the cycle after SKID fills.
- `in_ready` rises the cycle after SKID drains.
- `out_vector` and `out_err` are stable while `out_valid`=1 and `out_ready`=0.
- No combinational path from any input to any output.

## Test plan
- Reset and sweep, VECTOR_W=4, `out_ready`=1:
  - Release reset → `in_ready`=1 one edge later.
  - Send positions 0,1,2,3 back-to-back → `out_vector` = 0001, 0010, 0100, 1000 on consecutive cycles, each 1 cycle after acceptance, `out_err`=0.
- Zero request: `in_zero`=1 with `in_position`=2 → `out_vector`=0000, `out_err`=0, `err_cnt` unchanged.
- Out of range, VECTOR_W=5, POSITION_W=3:
  - Positions 5,6,7 → three beats with `out_vector`=00000, `out_err`=1; `err_cnt`=3.
  - Position 4 → 10000, `out_err`=0.
- Backpressure: stream positions 1,2,3 with `out_ready`=0 after the first beat is presented.
  - Exactly two beats are accepted, then `in_ready`=0.
  - Release `out_ready` → outputs 0010, 0100, 1000 in order; `in_ready` returns to 1 the cycle after SKID drains.
- Counter saturation and clear, CNT_W=2:
  - 5 out-of-range requests → `err_cnt`=3.
  - `err_clr` asserted in the same cycle as another out-of-range acceptance → `err_cnt`=0 next cycle.
- Reset mid-operation: with state FULL, pulse `rst_n` low asynchronously (between edges) → `out_valid`=0 and `in_ready`=0 immediately. After release, no stale beat is output and the next input is decoded correctly.
